// File: rtl/seq_pkg.sv
// Shared definitions for the 0110 serial-string link (transmitter and detector side).
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
//
// Contents: FSM state codes, default header pattern, default idle line level,
// and the bit-counter width helper used by the transmitter.
package seq_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [3:0] HEADER_0110    = 4'b0110;
  // A high idle line never forms part of a 0110 match, so a detector stays parked.
  localparam logic       IDLE_LEVEL_DEF = 1'b1;

  // Counter must reach both 3 (header) and w-1 (payload).
  function automatic int cnt_width(input int w);
    return (w < 4) ? 2 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in / serial-out shift register, MSB presented first.
// Latency: ser_out shows par_in[WIDTH-1] the cycle after load_en; each shift_en advances one bit.
// Backpressure: none; caller sequences load_en/shift_en.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset (clears contents)
//   load_en           capture par_in (has priority over shift_en)
//   shift_en          shift contents one place toward the MSB, zero-filling the LSB
//   par_in[WIDTH-1:0] parallel word
//   ser_out           current MSB of the register
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sreg <= '0;
    end else if (load_en) begin
      sreg <= par_in;
    end else if (shift_en) begin
      // Shift operator rather than a slice so WIDTH=1 stays legal.
      sreg <= sreg << 1;
    end
  end

  assign ser_out = sreg[WIDTH-1];

endmodule

// File: rtl/seq_tx0110.sv
// Serial frame transmitter: header (bit 3 first) then payload MSB first on a registered line.
// Latency: header bit 3 on the line one cycle after the accepted load; done pulses WIDTH+4 cycles later.
// Backpressure: ready low from acceptance until the done cycle; load while ready=0 is ignored.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   load                payload valid, taken only when ready=1
//   data_in[WIDTH-1:0]  payload word, captured on the accepting edge
//   ready               can accept a load this cycle (registered)
//   busy                header or payload on the line (registered)
//   seq_out             serial line (registered)
//   done                one-cycle pulse in the first idle cycle after the last payload bit
module seq_tx0110
  import seq_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter logic [3:0] HEADER     = HEADER_0110,
  parameter logic       IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             seq_out,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          hdr_last;
  logic          data_last;
  logic          shift_en;
  logic          ser_bit;

  // ready is high exactly while state is IDLE, so it doubles as the accept qualifier.
  assign accept    = ready && load;
  assign hdr_last  = (state == S_HDR)  && (cnt == CW'(3));
  assign data_last = (state == S_DATA) && (cnt == CW'(WIDTH - 1));
  // Payload MSB is copied to the line on the HDR->DATA edge, so the shifter
  // advances on that edge and on every payload edge except the final one.
  assign shift_en  = hdr_last || ((state == S_DATA) && !data_last);

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clock    (clock),
    .reset    (reset),
    .load_en  (accept),
    .shift_en (shift_en),
    .par_in   (data_in),
    .ser_out  (ser_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      seq_out <= IDLE_LEVEL;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            state   <= S_HDR;
            cnt     <= '0;
            seq_out <= HEADER[3];
            ready   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_HDR: begin
          if (hdr_last) begin
            state   <= S_DATA;
            cnt     <= '0;
            seq_out <= ser_bit;
          end else begin
            cnt     <= cnt + 1'b1;
            // cnt 0,1,2 selects header bits 2,1,0 for the following cycle.
            seq_out <= HEADER[2'd2 - cnt[1:0]];
          end
        end
        S_DATA: begin
          if (data_last) begin
            state   <= S_IDLE;
            cnt     <= '0;
            seq_out <= IDLE_LEVEL;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            seq_out <= ser_bit;
          end
        end
        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          seq_out <= IDLE_LEVEL;
          ready   <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx0110.sv
// Bench for seq_tx0110 (WIDTH=8): directed frames, scoreboard queue of per-cycle
// expected outputs, plus a reference 0110 Moore detector listening on the line.
module tb_seq_tx0110;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] data_in;
  logic         ready;
  logic         busy;
  logic         seq_out;
  logic         done;

  always #5 clock = ~clock;

  seq_tx0110 #(
    .WIDTH      (W),
    .HEADER     (4'b0110),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .data_in (data_in),
    .ready   (ready),
    .busy    (busy),
    .seq_out (seq_out),
    .done    (done)
  );

  // Reference detector: output is high the cycle after the final 0 of 0110 is on the line.
  logic [3:0] hist;
  logic       det;
  always @(posedge clock) begin
    if (reset) hist <= 4'b1111;
    else       hist <= {hist[2:0], seq_out};
  end
  assign det = (hist == 4'b0110);

  typedef struct {
    logic so;
    logic rdy;
    logic bsy;
    logic dn;
    logic dt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  task automatic chk(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b want=%b", nm, cyc, got, want);
    end
  endtask

  function automatic exp_t mk(input logic so, input logic rdy, input logic bsy,
                              input logic dn, input logic dt);
    exp_t e;
    e.so = so; e.rdy = rdy; e.bsy = bsy; e.dn = dn; e.dt = dt;
    return e;
  endfunction

  // Monitor: one expected record per clock edge, compared #1 after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("seq_out", seq_out, e.so);
        chk("ready",   ready,   e.rdy);
        chk("busy",    busy,    e.bsy);
        chk("done",    done,    e.dn);
        chk("detector", det,    e.dt);
      end
    end
  end

  // Drive inputs for the next edge and queue what the outputs must be after it.
  task automatic step(input logic rst, input logic ld, input logic [W-1:0] d, input exp_t e);
    @(negedge clock);
    reset   = rst;
    load    = ld;
    data_in = d;
    exp_q.push_back(e);
    @(posedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  // One frame: index k=0 is the accepting edge. Vectors are MSB-first by k
  // (bit 12-k). d is driven at k=0, d_busy afterwards. Reset is raised at rst_k.
  task automatic frame(input logic [W-1:0] d, input logic [W-1:0] d_busy,
                       input logic [12:0] loads, input logic [12:0] line,
                       input logic [12:0] dets, input int rst_k);
    for (int k = 0; k < 13; k++) begin
      if (k == rst_k) begin
        step(1'b1, loads[12-k], d_busy, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        return;
      end
      step(1'b0, loads[12-k], (k == 0) ? d : d_busy,
           mk(line[12-k], k == 12, k != 12, k == 12, dets[12-k]));
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    step(1'b1, 1'b0, 8'h00, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b1, 8'h55, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    idle(10);

    // A5: 0110 1010 0101, then idle with done
    frame(8'hA5, 8'hA5, 13'b1000000000000, 13'b0110101001011, 13'b0000100000000, -1);
    idle(3);

    // Load held high: FF then 00 back-to-back, one idle bit between, 13-cycle period
    frame(8'hFF, 8'h00, 13'b1111111111111, 13'b0110111111111, 13'b0000100000000, -1);
    frame(8'h00, 8'h5A, 13'b1111111111111, 13'b0110000000001, 13'b0000100000000, -1);
    idle(3);

    // Loads at k=3 and k=7 with other data are ignored
    frame(8'h81, 8'h7E, 13'b1001000100000, 13'b0110100000011, 13'b0000100000000, -1);
    idle(2);

    // C3 aborted by reset (with load) during the 6th payload bit
    frame(8'hC3, 8'h99, 13'b1000000000100, 13'b0110110000000, 13'b0000100100000, 10);
    idle(4);

    // Fresh frame after the abort
    frame(8'h3C, 8'h3C, 13'b1000000000000, 13'b0110001111001, 13'b0000100000000, -1);
    idle(2);

    // 6C: detector fires on the header and twice inside the payload
    frame(8'h6C, 8'h6C, 13'b1000000000000, 13'b0110011011001, 13'b0000100010010, -1);
    idle(3);

    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size() == 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
